// File: rtl/seq_det_rr_sched_if.sv
// Bundle of scheduler-facing signals for the time-multiplexed "101" detector.
// The master drives the serial channels and clear requests; the slave is the detector.
interface seq_det_rr_sched_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic               en;
  logic [NCH-1:0]     ch_valid;
  logic [NCH-1:0]     ch_bit;
  logic [NCH-1:0]     ch_ready;
  logic               clr;
  logic [CHW-1:0]     clr_ch;
  logic               match_valid;
  logic [CHW-1:0]     match_ch;
  logic [NCH*CW-1:0]  hit_cnt;

  modport master (
    output en, ch_valid, ch_bit, clr, clr_ch,
    input  ch_ready, match_valid, match_ch, hit_cnt
  );

  modport slave (
    input  en, ch_valid, ch_bit, clr, clr_ch,
    output ch_ready, match_valid, match_ch, hit_cnt
  );
endinterface

// File: rtl/seq_det_rr_sched.sv
// One "101" Moore detector engine shared round-robin across NCH serial channels,
// with per-channel saved state, registered match pulse and saturating hit counters.
module seq_det_rr_sched #(
  parameter int NCH     = 4,
  parameter int OVERLAP = 0,
  parameter int CW      = 8
) (
  input logic               clk,
  input logic               rst,
  seq_det_rr_sched_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } det_state_e;

  // With overlap, the trailing '1' of a match already counts as the start of the next "10".
  function automatic det_state_e det_next(input det_state_e s, input logic b);
    det_state_e n;
    n = IDLE;
    case (s)
      IDLE:    n = b ? S1 : IDLE;
      S1:      n = b ? S1 : S10;
      S10:     n = b ? S101 : IDLE;
      S101:    n = b ? S1 : ((OVERLAP != 0) ? S10 : IDLE);
      default: n = IDLE;
    endcase
    return n;
  endfunction

  det_state_e     state_q [NCH];
  det_state_e     state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] match_ch_q, match_ch_d;
  logic           match_valid_q, match_valid_d;

  logic [CHW-1:0] grant_idx;
  logic [CHW:0]   probe;
  logic           grant_found;
  logic [NCH-1:0] ready;
  logic [NCH-1:0] clr_hit;
  logic           transfer;
  det_state_e     adv_state;

  // Rotating priority search starting at ptr; probe carries one extra bit so the wrap is exact.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int i = 0; i < NCH; i++) begin
      probe = {1'b0, ptr_q} + (CHW+1)'(i);
      if (probe >= (CHW+1)'(NCH)) begin
        probe = probe - (CHW+1)'(NCH);
      end
      if (!grant_found && bus.ch_valid[probe[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = probe[CHW-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (bus.en && grant_found) begin
      ready[grant_idx] = 1'b1;
    end
    transfer = |(bus.ch_valid & ready);
  end

  always_comb begin
    clr_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      clr_hit[k] = bus.clr && (bus.clr_ch == CHW'(k));
    end
  end

  // A clear on the granted channel overrides its step, but the grant still moves the pointer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    adv_state     = det_next(state_q[grant_idx], bus.ch_bit[grant_idx]);

    if (transfer) begin
      ptr_d              = (grant_idx == CHW'(NCH-1)) ? '0 : grant_idx + CHW'(1);
      state_d[grant_idx] = adv_state;
      if ((adv_state == S101) && !clr_hit[grant_idx]) begin
        match_valid_d = 1'b1;
        match_ch_d    = grant_idx;
        if (cnt_q[grant_idx] != '1) begin
          cnt_d[grant_idx] = cnt_q[grant_idx] + CW'(1);
        end
      end
    end

    for (int k = 0; k < NCH; k++) begin
      if (clr_hit[k]) begin
        state_d[k] = IDLE;
        cnt_d[k]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  assign bus.ch_ready    = ready;
  assign bus.match_valid = match_valid_q;
  assign bus.match_ch    = match_ch_q;

  for (genvar g = 0; g < NCH; g++) begin : g_hit
    assign bus.hit_cnt[g*CW +: CW] = cnt_q[g];
  end
endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Bench for seq_det_rr_sched: three instances (non-overlap, overlap, 2-bit counters) share
// one stimulus stream and are checked against directed vectors and a history-based model.
module tb_seq_det_rr_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ch_valid;
  logic [3:0] ch_bit;
  logic       clr;
  logic [1:0] clr_ch;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  seq_det_rr_sched_if #(.NCH(4), .CW(8)) bus0 ();
  seq_det_rr_sched_if #(.NCH(4), .CW(8)) bus1 ();
  seq_det_rr_sched_if #(.NCH(4), .CW(2)) bus2 ();

  seq_det_rr_sched #(.NCH(4), .OVERLAP(0), .CW(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seq_det_rr_sched #(.NCH(4), .OVERLAP(1), .CW(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  seq_det_rr_sched #(.NCH(4), .OVERLAP(0), .CW(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.en = en;  assign bus0.ch_valid = ch_valid;  assign bus0.ch_bit = ch_bit;
  assign bus0.clr = clr;  assign bus0.clr_ch = clr_ch;
  assign bus1.en = en;  assign bus1.ch_valid = ch_valid;  assign bus1.ch_bit = ch_bit;
  assign bus1.clr = clr;  assign bus1.clr_ch = clr_ch;
  assign bus2.en = en;  assign bus2.ch_valid = ch_valid;  assign bus2.ch_bit = ch_bit;
  assign bus2.clr = clr;  assign bus2.clr_ch = clr_ch;

  logic [3:0]  rdy_w [3];
  logic        mv_w  [3];
  logic [1:0]  mch_w [3];
  logic [31:0] hc0, hc1;
  logic [7:0]  hc2;

  assign rdy_w[0] = bus0.ch_ready;  assign mv_w[0] = bus0.match_valid;  assign mch_w[0] = bus0.match_ch;
  assign rdy_w[1] = bus1.ch_ready;  assign mv_w[1] = bus1.match_valid;  assign mch_w[1] = bus1.match_ch;
  assign rdy_w[2] = bus2.ch_ready;  assign mv_w[2] = bus2.match_valid;  assign mch_w[2] = bus2.match_ch;
  assign hc0 = bus0.hit_cnt;
  assign hc1 = bus1.hit_cnt;
  assign hc2 = bus2.hit_cnt;

  // Reference model: each channel remembers the bits it consumed since its last restart point.
  int ovl_p [3] = '{0, 1, 0};
  int cw_p  [3] = '{8, 8, 2};
  int hist  [3][4];
  int hlen  [3][4];
  int cnt   [3][4];
  bit exp_mv  [3];
  int exp_mch [3];
  int ptr_m;

  typedef struct {
    bit         r;
    bit         e;
    logic [3:0] v;
    logic [3:0] b;
    bit         c;
    logic [1:0] cc;
    logic [3:0] rdy;
    bit         mv0;
    int         mch0;
    bit         mv1;
    int         cch;
    int         e0;
    int         e1;
    int         e2;
  } vec_t;

  vec_t vecs[$];

  function automatic int hitOf(input int d, input int ch);
    case (d)
      0:       return int'(hc0[ch*8 +: 8]);
      1:       return int'(hc1[ch*8 +: 8]);
      default: return int'(hc2[ch*2 +: 2]);
    endcase
  endfunction

  function automatic int modelGrant();
    if (!en) return -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr_m + i) % 4;
      if (ch_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [3:0] v, input logic [3:0] b,
                               input bit c, input logic [1:0] cc);
    int         g;
    logic [3:0] er;
    rst = r;  en = e;  ch_valid = v;  ch_bit = b;  clr = c;  clr_ch = cc;
    #1;
    if (!r) begin
      g  = modelGrant();
      er = (g < 0) ? 4'b0000 : (4'b0001 << g);
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("d%0d_ready", d), 32'(rdy_w[d]), 32'(er));
      end
    end
  endtask

  task automatic advanceClock();
    int g;
    g = modelGrant();
    @(posedge clk);
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 4; k++) begin
          hist[d][k] = 0;  hlen[d][k] = 0;  cnt[d][k] = 0;
        end
        exp_mv[d]  = 1'b0;
        exp_mch[d] = 0;
      end
      ptr_m = 0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        exp_mv[d] = 1'b0;
        if (g >= 0 && !(clr && int'(clr_ch) == g)) begin
          hist[d][g] = ((hist[d][g] << 1) | int'(ch_bit[g])) & 7;
          hlen[d][g]++;
          if (hlen[d][g] >= 3 && hist[d][g] == 5) begin
            exp_mv[d]  = 1'b1;
            exp_mch[d] = g;
            if (cnt[d][g] < (1 << cw_p[d]) - 1) cnt[d][g]++;
            if (ovl_p[d] == 0) begin
              hist[d][g] = 0;
              hlen[d][g] = 0;
            end
          end
        end
        if (clr) begin
          hist[d][clr_ch] = 0;  hlen[d][clr_ch] = 0;  cnt[d][clr_ch] = 0;
        end
      end
      if (g >= 0) ptr_m = (g + 1) % 4;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("d%0d_match_valid", d), 32'(mv_w[d]), 32'(exp_mv[d]));
      checkOutput($sformatf("d%0d_match_ch", d), 32'(mch_w[d]), 32'(exp_mch[d]));
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("d%0d_hit_cnt%0d", d, k), 32'(hitOf(d, k)), 32'(cnt[d][k]));
      end
    end
  endtask

  task automatic addVec(input bit r, input bit e, input logic [3:0] v, input logic [3:0] b,
                        input bit c, input logic [1:0] cc, input logic [3:0] rdy,
                        input bit mv0, input int mch0, input bit mv1,
                        input int cch, input int e0, input int e1, input int e2);
    vec_t t;
    t.r = r;  t.e = e;  t.v = v;  t.b = b;  t.c = c;  t.cc = cc;  t.rdy = rdy;
    t.mv0 = mv0;  t.mch0 = mch0;  t.mv1 = mv1;  t.cch = cch;  t.e0 = e0;  t.e1 = e1;  t.e2 = e2;
    vecs.push_back(t);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Channel 0 alone: 1,0,1,0,1 (second hit only with overlap)
    addVec(1,1,4'b0000,4'b0000,0,0,4'b0000, 0,0,0, 0,0,0,0);
    addVec(0,1,4'b0001,4'b0001,0,0,4'b0001, 0,0,0, 0,0,0,0);
    addVec(0,1,4'b0001,4'b0000,0,0,4'b0001, 0,0,0, 0,0,0,0);
    addVec(0,1,4'b0001,4'b0001,0,0,4'b0001, 1,0,1, 0,1,1,1);
    addVec(0,1,4'b0001,4'b0000,0,0,4'b0001, 0,0,0, 0,1,1,1);
    addVec(0,1,4'b0001,4'b0001,0,0,4'b0001, 0,0,1, 0,1,2,1);
    // All four valid: interleaved 1,0,1 with decoy bits on the idle lanes
    addVec(1,1,4'b0000,4'b0000,0,0,4'b0000, 0,0,0, 0,0,0,0);
    addVec(0,1,4'b1111,4'b1111,0,0,4'b0001, 0,0,0, 0,0,0,0);
    addVec(0,1,4'b1111,4'b1111,0,0,4'b0010, 0,0,0, 1,0,0,0);
    addVec(0,1,4'b1111,4'b1111,0,0,4'b0100, 0,0,0, 2,0,0,0);
    addVec(0,1,4'b1111,4'b1111,0,0,4'b1000, 0,0,0, 3,0,0,0);
    addVec(0,1,4'b1111,4'b1110,0,0,4'b0001, 0,0,0, 0,0,0,0);
    addVec(0,1,4'b1111,4'b1101,0,0,4'b0010, 0,0,0, 1,0,0,0);
    addVec(0,1,4'b1111,4'b1011,0,0,4'b0100, 0,0,0, 2,0,0,0);
    addVec(0,1,4'b1111,4'b0111,0,0,4'b1000, 0,0,0, 3,0,0,0);
    addVec(0,1,4'b1111,4'b0001,0,0,4'b0001, 1,0,1, 0,1,1,1);
    addVec(0,1,4'b1111,4'b0010,0,0,4'b0010, 1,1,1, 1,1,1,1);
    addVec(0,1,4'b1111,4'b0100,0,0,4'b0100, 1,2,1, 2,1,1,1);
    addVec(0,1,4'b1111,4'b1000,0,0,4'b1000, 1,3,1, 3,1,1,1);
    // Channel 2: clear collides with the completing bit, then a fresh 1,0,1
    addVec(0,1,4'b0100,4'b0100,0,0,4'b0100, 0,3,0, 2,1,1,1);
    addVec(0,1,4'b0100,4'b0000,0,0,4'b0100, 0,3,0, 2,1,1,1);
    addVec(0,1,4'b0100,4'b0100,1,2,4'b0100, 0,3,0, 2,0,0,0);
    addVec(0,1,4'b0100,4'b0100,0,0,4'b0100, 0,3,0, 2,0,0,0);
    addVec(0,1,4'b0100,4'b0000,0,0,4'b0100, 0,3,0, 2,0,0,0);
    addVec(0,1,4'b0100,4'b0100,0,0,4'b0100, 1,2,1, 2,1,1,1);
    // Channel 3: reset mid-sequence, then en low holds state, then clear while disabled
    addVec(1,1,4'b0000,4'b0000,0,0,4'b0000, 0,0,0, 3,0,0,0);
    addVec(0,1,4'b1000,4'b1000,0,0,4'b1000, 0,0,0, 3,0,0,0);
    addVec(0,1,4'b1000,4'b0000,0,0,4'b1000, 0,0,0, 3,0,0,0);
    addVec(1,1,4'b1000,4'b1000,0,0,4'b0000, 0,0,0, 3,0,0,0);
    addVec(0,1,4'b1000,4'b1000,0,0,4'b1000, 0,0,0, 3,0,0,0);
    addVec(0,0,4'b1000,4'b0000,0,0,4'b0000, 0,0,0, 3,0,0,0);
    addVec(0,0,4'b1000,4'b0000,0,0,4'b0000, 0,0,0, 3,0,0,0);
    addVec(0,1,4'b1000,4'b0000,0,0,4'b1000, 0,0,0, 3,0,0,0);
    addVec(0,1,4'b1000,4'b1000,0,0,4'b1000, 1,3,1, 3,1,1,1);
    addVec(0,0,4'b1000,4'b1000,1,3,4'b0000, 0,3,0, 3,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].v, vecs[i].b, vecs[i].c, vecs[i].cc);
      if (!vecs[i].r) checkOutput($sformatf("tbl%0d_ready", i), 32'(rdy_w[0]), 32'(vecs[i].rdy));
      advanceClock();
      checkOutput($sformatf("tbl%0d_mv0", i), 32'(mv_w[0]), 32'(vecs[i].mv0));
      checkOutput($sformatf("tbl%0d_mch0", i), 32'(mch_w[0]), 32'(vecs[i].mch0));
      checkOutput($sformatf("tbl%0d_mv1", i), 32'(mv_w[1]), 32'(vecs[i].mv1));
      checkOutput($sformatf("tbl%0d_cnt0", i), 32'(hitOf(0, vecs[i].cch)), 32'(vecs[i].e0));
      checkOutput($sformatf("tbl%0d_cnt1", i), 32'(hitOf(1, vecs[i].cch)), 32'(vecs[i].e1));
      checkOutput($sformatf("tbl%0d_cnt2", i), 32'(hitOf(2, vecs[i].cch)), 32'(vecs[i].e2));
    end

    // Channel 1 sends "101" five times: the 2-bit counter sticks at 3
    applyStimulus(1, 1, 4'b0000, 4'b0000, 0, 0);
    advanceClock();
    for (int rep = 0; rep < 5; rep++) begin
      applyStimulus(0, 1, 4'b0010, 4'b0010, 0, 0);  advanceClock();
      applyStimulus(0, 1, 4'b0010, 4'b0000, 0, 0);  advanceClock();
      applyStimulus(0, 1, 4'b0010, 4'b0010, 0, 0);  advanceClock();
      checkOutput($sformatf("sat_pulse%0d", rep), 32'(mv_w[2]), 32'd1);
    end
    checkOutput("sat_cnt_cw2", 32'(hitOf(2, 1)), 32'd3);
    checkOutput("sat_cnt_cw8", 32'(hitOf(0, 1)), 32'd5);

    // Random traffic against the model, including occasional resets and clears
    applyStimulus(1, 1, 4'b0000, 4'b0000, 0, 0);
    advanceClock();
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom % 200) == 0, ($urandom % 8) != 0, 4'($urandom), 4'($urandom),
                    ($urandom % 6) == 0, 2'($urandom));
      advanceClock();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/seq_det_rr_sched.md
Name: seq_det_rr_sched

Overview:
- Time-multiplexes one bit-serial "101" Moore sequence-detector engine across NCH independent serial input channels.
- A round-robin scheduler grants one channel per cycle, loads that channel's saved detector state, advances it by one bit and writes the new state back.
- Reports matches as a registered pulse with the channel index, and keeps a per-channel saturating hit counter.
- Sits between the serial front-ends and the status/interrupt logic.

Parameters:
- NCH, 4, number of input channels (2..16).
- OVERLAP, 0, 0 = non-overlapping detection, 1 = overlapping (the final '1' of a match may start the next one).
- CW, 8, width of each per-channel hit counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scheduler enable; when low no grants are issued.
- ch_valid  input  NCH  per-channel bit-valid.
- ch_bit  input  NCH  per-channel serial data bit.
- ch_ready  output  NCH  one-hot grant, combinational from ch_valid, ptr and en.
- clr  input  1  clear request for channel clr_ch.
- clr_ch  input  $clog2(NCH)  channel to clear.
- match_valid  output  1  registered one-cycle match pulse.
- match_ch  output  $clog2(NCH)  channel index of the match; valid only when match_valid=1.
- hit_cnt  output  NCH*CW  flattened per-channel hit counters; channel k occupies bits [k*CW +: CW].

Behaviour:
- Reset:
  - rst is sampled on clk rising edge.
  - All channel states go to IDLE, ptr=0, all hit_cnt=0, match_valid=0, match_ch=0.
  - A reset asserted mid-stream discards all partial sequences.
- Arbitration:
  - Grant the first channel k with ch_valid[k]=1, searching from ptr upward with wrap to 0.
  - ch_ready = onehot(k) when en=1 and any valid is present; otherwise ch_ready=0.
  - A transfer occurs when ch_valid[k]&ch_ready[k]; at most one transfer per cycle.
  - After a transfer, ptr <= (k+1) mod NCH. With no transfer, ptr holds.
  - ch_valid may drop without a transfer; the scheduler does not hold a grant.
- Per-channel state is 2 bits: IDLE, S1, S10, S101. Only the granted channel's state changes on a transfer. Transitions on the consumed bit b:
  - IDLE: b=1 -> S1; b=0 -> IDLE.
  - S1: b=1 -> S1; b=0 -> S10.
  - S10: b=1 -> S101 (match); b=0 -> IDLE.
  - S101, OVERLAP=0: b=1 -> S1; b=0 -> IDLE.
  - S101, OVERLAP=1: b=1 -> S1; b=0 -> S10.
- Match output:
  - A match is any transfer whose next state is S101.
  - The cycle after such a transfer: match_valid=1, match_ch=k.
  - Otherwise match_valid=0; match_ch holds its last value.
  - Latency from the accepted bit to match_valid is 1 cycle.
- Hit counters:
  - hit_cnt[k] increments on each match of channel k.
  - It saturates at 2^CW-1 and does not wrap.
- Clear:
  - clr=1 sets the state of clr_ch to IDLE and its hit_cnt to 0 at the next edge.
  - If clr hits the channel being transferred in the same cycle, the clear wins: state IDLE, no match pulse, counter 0. The transfer still counts for ptr advance.
  - clr on a different channel than the transferred one: both take effect.
  - clr_ch >= NCH is ignored.
- en=0: ch_ready=0, states and ptr held; clr still honoured.
- All outputs except ch_ready are registered.

Test Plan:
- Reset then channel 0 alone sends 1,0,1 (OVERLAP=0) -> match_valid=1 with match_ch=0 exactly one cycle after the third bit; hit_cnt[0]=1.
- Channel 0 sends 1,0,1,0,1: OVERLAP=0 gives hit_cnt[0]=1; OVERLAP=1 gives hit_cnt[0]=2, with pulses after bits 3 and 5.
- All 4 channels hold valid continuously -> grants in order 0,1,2,3,0,...; each channel's interleaved bits 1,0,1 produce matches at ch 0,1,2,3 on consecutive cycles, and states never cross-contaminate.
- Channel 2 sends 1,0; clr with clr_ch=2 coincides with its next bit 1 -> no match, state IDLE, hit_cnt[2]=0. A fresh 1,0,1 afterwards then matches once.
- CW=2 with channel 1 sending "101" repeated 5 times (non-overlap) -> hit_cnt[1] sticks at 3.
- Mid-sequence rst after 1,0 on channel 3, then bit 1 -> no match. en=0 with valid high -> ch_ready=0 and state unchanged.
